pcs_rx_gearbox_lock: RTL

//  Per-lane RX front end of the 40G PCS; the receive counterpart that consumes what pcs_40g_tx emits on
//  its PMA lanes. Converts a 64-bit/cycle PMA bit stream into 66-bit blocks (64b/66b gearbox) and runs
//  the IEEE 802.3 cl.82 block-lock FSM, slipping alignment one bit at a time until sync headers lock.
//  One instance per lane; output feeds the lane alignment-marker lock / deskew stage.

---
 rtl/pcs_rx_gearbox_lock_if.sv | 37 +++
 rtl/pcs_rx_gearbox_lock.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_gearbox_lock_if.sv
// pcs_rx_gearbox_lock_if: per-lane RX stream bundle between the PMA side and the block-lock front end.
//   pma_i        PMA word, bit 0 received first, valid every cycle.
//   valid_o      block on head_o/data_o is valid this cycle.
//   head_o       sync header (block bits [1:0]).
//   data_o       block payload (block bits [65:2]).
//   block_lock_o block lock achieved.
//   slip_o       one-cycle pulse: alignment moved by one bit.
// Modports: master drives the PMA word and observes blocks; slave is the gearbox/lock block.
interface pcs_rx_gearbox_lock_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned HEAD_W = 2
);
  logic [DATA_W-1:0] pma_i;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;
  logic              block_lock_o;
  logic              slip_o;

  modport master (
    output pma_i,
    input  valid_o,
    input  head_o,
    input  data_o,
    input  block_lock_o,
    input  slip_o
  );

  modport slave (
    input  pma_i,
    output valid_o,
    output head_o,
    output data_o,
    output block_lock_o,
    output slip_o
  );
endinterface

// File: rtl/pcs_rx_gearbox_lock.sv
// pcs_rx_gearbox_lock: per-lane 40G PCS RX front end. Gears a 64-bit/cycle PMA stream into 66-bit
// blocks and runs the cl.82 block-lock FSM, slipping alignment one bit at a time until sync headers
// lock. Output feeds the lane alignment-marker lock / deskew stage.
// Ports:
//   clk     clock
//   nreset  synchronous, active-low reset
//   rx      slave side of pcs_rx_gearbox_lock_if (pma_i in; valid_o, head_o, data_o,
//           block_lock_o, slip_o out, all registered)
module pcs_rx_gearbox_lock #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned HEAD_W   = 2,
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned WIN_CNT  = 1024,
  parameter int unsigned BAD_MAX  = 65
) (
  input logic                   clk,
  input logic                   nreset,
  pcs_rx_gearbox_lock_if.slave  rx
);

  localparam int unsigned BLK_W  = DATA_W + HEAD_W;
  localparam int unsigned BUF_W  = 2 * BLK_W;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);
  localparam int unsigned SH_W   = $clog2(WIN_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(BAD_MAX + 1);

  typedef enum logic [1:0] {StResetCnt, StTestSh, StSlip, StLocked} state_e;

  state_e              r_state;
  logic [BUF_W-1:0]    r_buf;       // pending bits, oldest at bit 0; bits >= r_fill kept zero
  logic [FILL_W-1:0]   r_fill;
  logic                r_valid;
  logic [HEAD_W-1:0]   r_head;
  logic [DATA_W-1:0]   r_data;
  logic                r_lock;
  logic                r_slip;
  logic                r_slip_pend; // slip_o was high last cycle: drop one bit this cycle
  logic                r_holdoff;   // skip testing the first block after a slip
  logic [SH_W-1:0]     r_sh_cnt;
  logic [BAD_W-1:0]    r_bad_cnt;

  logic [BUF_W-1:0]    w_base;
  logic [FILL_W-1:0]   w_fill_a;
  logic [DATA_W-1:0]   w_in;
  logic [FILL_W-1:0]   w_in_n;
  logic [BUF_W-1:0]    w_cat;
  logic [FILL_W-1:0]   w_fill_t;
  logic                w_take;
  logic                w_hdr_ok;
  logic [SH_W-1:0]     w_sh_inc;
  logic [BAD_W-1:0]    w_bad_inc;

  always_comb begin
    w_base   = r_buf;
    w_fill_a = r_fill;
    w_in     = rx.pma_i;
    w_in_n   = FILL_W'(DATA_W);
    if (r_slip_pend) begin
      if (r_fill != '0) begin
        w_base   = r_buf >> 1;
        w_fill_a = r_fill - FILL_W'(1);
      end else begin
        // Nothing pending: the discarded bit is the first bit of the incoming word.
        w_in   = rx.pma_i >> 1;
        w_in_n = FILL_W'(DATA_W - 1);
      end
    end
    w_cat     = w_base | (BUF_W'(w_in) << w_fill_a);
    w_fill_t  = w_fill_a + w_in_n;
    w_take    = (w_fill_t >= FILL_W'(BLK_W));
    w_hdr_ok  = ^r_head;  // 01 or 10
    w_sh_inc  = r_sh_cnt + SH_W'(1);
    w_bad_inc = r_bad_cnt + BAD_W'(!w_hdr_ok);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state     <= StResetCnt;
      r_buf       <= '0;
      r_fill      <= '0;
      r_valid     <= 1'b0;
      r_head      <= '0;
      r_data      <= '0;
      r_lock      <= 1'b0;
      r_slip      <= 1'b0;
      r_slip_pend <= 1'b0;
      r_holdoff   <= 1'b0;
      r_sh_cnt    <= '0;
      r_bad_cnt   <= '0;
    end else begin
      // Gearbox
      if (w_take) begin
        r_valid <= 1'b1;
        r_head  <= w_cat[HEAD_W-1:0];
        r_data  <= w_cat[BLK_W-1:HEAD_W];
        r_buf   <= w_cat >> BLK_W;
        r_fill  <= w_fill_t - FILL_W'(BLK_W);
      end else begin
        r_valid <= 1'b0;
        r_buf   <= w_cat;
        r_fill  <= w_fill_t;
      end
      r_slip_pend <= r_slip;
      r_slip      <= 1'b0;

      // Block-lock FSM; headers are tested in the cycle they sit on the outputs.
      unique case (r_state)
        StResetCnt: begin
          r_sh_cnt  <= '0;
          r_bad_cnt <= '0;
          r_holdoff <= 1'b0;
          r_state   <= StTestSh;
        end
        StTestSh: begin
          if (r_valid) begin
            if (r_holdoff) begin
              r_holdoff <= 1'b0;
            end else if (w_hdr_ok) begin
              if (w_sh_inc == SH_W'(LOCK_CNT)) begin
                r_lock    <= 1'b1;
                r_sh_cnt  <= '0;
                r_bad_cnt <= '0;
                r_state   <= StLocked;
              end else begin
                r_sh_cnt <= w_sh_inc;
              end
            end else begin
              r_slip  <= 1'b1;
              r_state <= StSlip;
            end
          end
        end
        StSlip: begin
          r_sh_cnt  <= '0;
          r_bad_cnt <= '0;
          r_holdoff <= 1'b1;
          r_state   <= StTestSh;
        end
        StLocked: begin
          if (r_valid) begin
            // Loss of lock takes priority over a simultaneous window end.
            if (w_bad_inc == BAD_W'(BAD_MAX)) begin
              r_lock    <= 1'b0;
              r_slip    <= 1'b1;
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
              r_state   <= StSlip;
            end else if (w_sh_inc == SH_W'(WIN_CNT)) begin
              r_sh_cnt  <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_sh_cnt  <= w_sh_inc;
              r_bad_cnt <= w_bad_inc;
            end
          end
        end
        default: r_state <= StResetCnt;
      endcase
    end
  end

  assign rx.valid_o      = r_valid;
  assign rx.head_o       = r_head;
  assign rx.data_o       = r_data;
  assign rx.block_lock_o = r_lock;
  assign rx.slip_o       = r_slip;

endmodule
